// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the L2 arbiter between the L1 I-cache and D-cache miss paths.
package l2_arb_pkg;

  localparam int LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

endpackage

// File: rtl/l2_arbiter_if.sv
// Bundle of the I-cache, D-cache and L2 memory-side signals seen by the arbiter.
interface l2_arbiter_if
  import l2_arb_pkg::*;
#(
  parameter int s_line = LINE_W
);
  logic              i_mem_read;
  logic [31:0]       i_mem_address;
  logic [s_line-1:0] i_mem_rdata;
  logic              i_mem_resp;

  logic              d_mem_read;
  logic              d_mem_write;
  logic [31:0]       d_mem_address;
  logic [s_line-1:0] d_mem_wdata;
  logic [s_line-1:0] d_mem_rdata;
  logic              d_mem_resp;

  logic              l2_read;
  logic              l2_write;
  logic [31:0]       l2_address;
  logic [s_line-1:0] l2_wdata;
  logic [s_line-1:0] l2_rdata;
  logic              l2_resp;

  // arbiter view
  modport master (
    input  i_mem_read, i_mem_address,
    output i_mem_rdata, i_mem_resp,
    input  d_mem_read, d_mem_write, d_mem_address, d_mem_wdata,
    output d_mem_rdata, d_mem_resp,
    output l2_read, l2_write, l2_address, l2_wdata,
    input  l2_rdata, l2_resp
  );

  // caches and L2 view
  modport slave (
    output i_mem_read, i_mem_address,
    input  i_mem_rdata, i_mem_resp,
    output d_mem_read, d_mem_write, d_mem_address, d_mem_wdata,
    input  d_mem_rdata, d_mem_resp,
    input  l2_read, l2_write, l2_address, l2_wdata,
    output l2_rdata, l2_resp
  );
endinterface

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing one L2 port between the I-cache and D-cache miss paths.
//
// state   | meaning
// IDLE    | no L2 command; pick a pending requester (tie goes opposite last_grant)
// SERVE_I | latched I-cache read on L2; wait for l2_resp
// SERVE_D | latched D-cache read/write on L2; wait for l2_resp
module l2_arbiter
  import l2_arb_pkg::*;
#(
  parameter int s_offset = 5,
  parameter int s_line   = LINE_W
) (
  input logic          clk,
  input logic          rst,
  l2_arbiter_if.master bus
);

  localparam logic [31:0] ADDR_MASK = ~((32'h1 << s_offset) - 32'h1);

  arb_state_t        state, state_nxt;
  grant_t            last_grant;
  logic [31:0]       cmd_addr;
  logic [s_line-1:0] cmd_wdata;
  logic              cmd_read, cmd_write;
  logic              i_pend, d_pend;
  logic              take_i, take_d;

  assign i_pend = bus.i_mem_read;
  assign d_pend = bus.d_mem_read | bus.d_mem_write;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    take_i         = 1'b0;
    take_d         = 1'b0;
    bus.i_mem_resp = 1'b0;
    bus.d_mem_resp = 1'b0;
    case (state)
      IDLE: begin
        if (i_pend && (!d_pend || last_grant == GRANT_D)) begin
          take_i    = 1'b1;
          state_nxt = SERVE_I;
        end else if (d_pend) begin
          take_d    = 1'b1;
          state_nxt = SERVE_D;
        end
      end
      SERVE_I: begin
        if (bus.l2_resp) begin
          bus.i_mem_resp = 1'b1;
          state_nxt      = IDLE;
        end
      end
      SERVE_D: begin
        if (bus.l2_resp) begin
          bus.d_mem_resp = 1'b1;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write wins when the D side illegally raises read and write together.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GRANT_D;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      cmd_read   <= 1'b0;
      cmd_write  <= 1'b0;
    end else if (take_i) begin
      last_grant <= GRANT_I;
      cmd_addr   <= bus.i_mem_address & ADDR_MASK;
      cmd_wdata  <= '0;
      cmd_read   <= 1'b1;
      cmd_write  <= 1'b0;
    end else if (take_d) begin
      last_grant <= GRANT_D;
      cmd_addr   <= bus.d_mem_address & ADDR_MASK;
      cmd_wdata  <= bus.d_mem_wdata;
      cmd_read   <= bus.d_mem_read & ~bus.d_mem_write;
      cmd_write  <= bus.d_mem_write;
    end
  end

  assign bus.l2_read     = (state != IDLE) & cmd_read;
  assign bus.l2_write    = (state != IDLE) & cmd_write;
  assign bus.l2_address  = cmd_addr;
  assign bus.l2_wdata    = cmd_wdata;
  assign bus.i_mem_rdata = bus.l2_rdata;
  assign bus.d_mem_rdata = bus.l2_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Scoreboard bench for l2_arbiter: expected L2 commands are queued at request time and popped as they appear.
module tb_l2_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l2_arbiter_if #(.s_line(256)) bus ();

  l2_arbiter #(.s_offset(5), .s_line(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    bit           side_d;
    bit           rd;
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mdl_last_d = 1'b1;
  bit   rr_mode = 1'b0;
  int   rr_cnt = 0;
  int   cyc = 0;
  int   last_resp_cyc = 0;
  bit   cmd_prev = 1'b0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_i(input logic [31:0] aligned);
    exp_t e;
    e.side_d = 1'b0; e.rd = 1'b1; e.wr = 1'b0; e.addr = aligned; e.wdata = '0;
    exp_q.push_back(e);
    mdl_last_d = 1'b0;
  endtask

  task automatic push_d(input bit wr, input logic [31:0] aligned, input logic [255:0] wd);
    exp_t e;
    e.side_d = 1'b1; e.rd = !wr; e.wr = wr; e.addr = aligned; e.wdata = wd;
    exp_q.push_back(e);
    mdl_last_d = 1'b1;
  endtask

  task automatic wait_cmd();
    int n = 0;
    while (!(bus.l2_read || bus.l2_write) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) chk("cmd_timeout", 1, 0);
  endtask

  task automatic respond(input int lat, input logic [255:0] rdata);
    repeat (lat) begin @(posedge clk); #1; end
    bus.l2_resp  = 1'b1;
    bus.l2_rdata = rdata;
    @(posedge clk); #1;
    bus.l2_resp  = 1'b0;
  endtask

  // Monitor: command starts pop the scoreboard; resp steering checked every cycle.
  always @(negedge clk) begin
    bit active, exp_i, exp_d;
    cyc++;
    active = bus.l2_read || bus.l2_write;
    if (active && !cmd_prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_cmd", 1, 0);
      end else begin
        cur = exp_q.pop_front();
        chk("cmd_read", bus.l2_read, cur.rd);
        chk("cmd_write", bus.l2_write, cur.wr);
        if (rr_mode) begin
          if (rr_cnt > 0) chk("rr_gap", cyc - last_resp_cyc, 2);
          rr_cnt++;
        end
      end
    end
    if (active) begin
      chk("l2_address", bus.l2_address, cur.addr);
      chk("l2_wdata", bus.l2_wdata, cur.wdata);
    end
    exp_i = bus.l2_resp && active && !cur.side_d;
    exp_d = bus.l2_resp && active && cur.side_d;
    chk("i_mem_resp", bus.i_mem_resp, exp_i);
    chk("d_mem_resp", bus.d_mem_resp, exp_d);
    if (bus.l2_resp) begin
      chk("i_mem_rdata", bus.i_mem_rdata, bus.l2_rdata);
      chk("d_mem_rdata", bus.d_mem_rdata, bus.l2_rdata);
      if (active) last_resp_cyc = cyc;
    end
    cmd_prev = active;
  end

  always @(negedge clk)
    assert (!(bus.d_mem_read && bus.d_mem_write)) else $error("illegal D read+write");

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.i_mem_read    = 1'b1;
    bus.i_mem_address = 32'h0000_1234;
    bus.d_mem_read    = 1'b0;
    bus.d_mem_write   = 1'b1;
    bus.d_mem_address = 32'h8000_0040;
    bus.d_mem_wdata   = {32{8'h11}};
    bus.l2_rdata      = '0;
    bus.l2_resp       = 1'b0;

    // Reset held two cycles with both requests high
    repeat (2) begin
      @(negedge clk);
      chk("rst_l2_read", bus.l2_read, 0);
      chk("rst_l2_write", bus.l2_write, 0);
      chk("rst_l2_address", bus.l2_address, 0);
      chk("rst_l2_wdata", bus.l2_wdata, 0);
    end
    push_i(32'h0000_1220);
    push_d(1'b1, 32'h8000_0040, {32{8'h11}});
    @(posedge clk); #1;
    rst = 1'b0;
    wait_cmd();
    chk("first_grant_i", bus.l2_read, 1);
    respond(2, {32{8'h5A}});
    bus.i_mem_read = 1'b0;

    // D write; wdata changes mid-transaction must not reach L2
    wait_cmd();
    bus.d_mem_wdata = {32{8'h22}};
    respond(3, {32{8'h33}});
    bus.d_mem_write = 1'b0;

    // Single I read: grant latency and 5-cycle L2 response
    bus.i_mem_address = 32'h0000_1234;
    push_i(32'h0000_1220);
    bus.i_mem_read = 1'b1;
    @(negedge clk);
    chk("grant_lat_t", bus.l2_read, 0);
    @(posedge clk); #1;
    chk("grant_lat_t1", bus.l2_read, 1);
    chk("grant_addr", bus.l2_address, 32'h0000_1220);
    respond(5, {32{8'hA5}});
    chk("resp_one_cycle", bus.i_mem_resp, 0);
    bus.i_mem_read = 1'b0;

    // Round-robin with both requests held
    rr_mode = 1'b1;
    bus.d_mem_address = 32'h8000_0117;
    bus.d_mem_wdata   = {32{8'h44}};
    bus.i_mem_address = 32'h0000_2FFF;
    for (int k = 0; k < 4; k++) begin
      if (mdl_last_d) push_i(32'h0000_2FE0);
      else            push_d(1'b0, 32'h8000_0100, {32{8'h44}});
    end
    bus.i_mem_read = 1'b1;
    bus.d_mem_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_cmd();
      respond(1, {8{k[31:0]}});
    end
    bus.i_mem_read = 1'b0;
    bus.d_mem_read = 1'b0;
    rr_mode = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rr_no_extra", bus.l2_read | bus.l2_write, 0);
    end

    // Reset during SERVE_I
    @(posedge clk); #1;
    bus.i_mem_address = 32'h0000_0040;
    push_i(32'h0000_0040);
    bus.i_mem_read = 1'b1;
    wait_cmd();
    rst = 1'b1;
    bus.i_mem_read = 1'b0;
    @(posedge clk); #1;
    chk("midrst_l2_read", bus.l2_read, 0);
    chk("midrst_l2_address", bus.l2_address, 0);
    rst = 1'b0;
    mdl_last_d = 1'b1;
    bus.l2_resp  = 1'b1;
    bus.l2_rdata = {32{8'hEE}};
    @(negedge clk);
    chk("idle_resp_ignored", bus.i_mem_resp, 0);
    @(posedge clk); #1;
    bus.l2_resp = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_idle", bus.l2_read | bus.l2_write, 0);
    end

    chk("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/l2_arbiter.md
# l2_arbiter

Two-port arbiter that shares the single unified L2 cache between the L1 instruction-cache miss path and the L1 data-cache miss path. It sits between the two L1 caches' memory sides and the L2 cache's CPU-side port. It grants one requester at a time and latches that requester's command for the whole transaction. Simultaneous requests are resolved round-robin.

## Interface
Parameters:
- `s_offset`, default 5 — line-offset bits; the low `s_offset` address bits are forced to 0 toward L2.
- `s_line`, default 256 — cache-line width in bits.

Ports:
- `clk`  in  1 — single clock; all state updates on rising edge.
- `rst`  in  1 — reset, synchronous, active-high.
- `i_mem_read`  in  1 — I-cache line-fill request; held until `i_mem_resp`.
- `i_mem_address`  in  32 — I-cache line address.
- `i_mem_rdata`  out  s_line — fill data to I-cache.
- `i_mem_resp`  out  1 — one-cycle completion pulse to I-cache.
- `d_mem_read`  in  1 — D-cache line-fill request; held until `d_mem_resp`.
- `d_mem_write`  in  1 — D-cache writeback request; held until `d_mem_resp`.
- `d_mem_address`  in  32 — D-cache line address.
- `d_mem_wdata`  in  s_line — D-cache writeback data.
- `d_mem_rdata`  out  s_line — fill data to D-cache.
- `d_mem_resp`  out  1 — one-cycle completion pulse to D-cache.
- `l2_read`  out  1 — read command to L2.
- `l2_write`  out  1 — write command to L2.
- `l2_address`  out  32 — latched line-aligned address.
- `l2_wdata`  out  s_line — latched write data.
- `l2_rdata`  in  s_line — L2 read data.
- `l2_resp`  in  1 — L2 completion pulse.

## Operation
- States: `IDLE`, `SERVE_I`, `SERVE_D`.
- **IDLE**
  - No L2 command is driven.
  - Only I pending → latch I command, go to `SERVE_I`.
  - Only D pending → latch D command, go to `SERVE_D`.
  - Both pending → grant the side opposite `last_grant`.
- **Latch at grant** (registered):
  - `cmd_addr` = address with the low `s_offset` bits zeroed.
  - `cmd_wdata` = `d_mem_wdata` for a D grant, else 0.
  - `cmd_read` and `cmd_write` flags.
  - `last_grant` is updated to the granted side.
- **SERVE_x**
  - `l2_read`/`l2_write`/`l2_address`/`l2_wdata` come from the latches.
  - Requester-side input changes are ignored until completion.
  - On `l2_resp`, pulse the granted side's `*_mem_resp` combinationally in the same cycle, then go to `IDLE`.
- **Mandatory IDLE cycle:** after every completion the FSM spends one cycle in `IDLE`. This gives the requester time to drop its request, so a stale request is never re-served.
- **Read data:** `i_mem_rdata` and `d_mem_rdata` both carry `l2_rdata` unconditionally. Only the `resp` signals are gated.
- **D read and write both asserted (illegal):** write takes priority. The bench flags this with an assertion.
- **`l2_resp` while in IDLE:** ignored; no `resp` is forwarded.

## Timing
- **Reset values:**
  - State `IDLE`; `last_grant` = D, so the first tie goes to I.
  - All latches 0.
  - `l2_read`, `l2_write`, `i_mem_resp`, `d_mem_resp` = 0.
  - `l2_address` = 0 and `l2_wdata` = 0.
- **Grant latency:** a request seen in IDLE during cycle t appears on the L2 command lines in cycle t+1.
- **Response latency:** 0 cycles. `l2_resp` in cycle n gives `*_mem_resp` in cycle n.
- **Back-to-back:** if L2 responds in cycle n, the next L2 command appears no earlier than cycle n+2.
- **Reset mid-transaction:** the FSM returns to `IDLE` at the next edge and commands drop. The L2 shares `rst`, so no transaction is resumed and no `resp` is emitted.
- **Starvation:** bounded. A pending requester waits at most one full transaction of the other side.

## Structure
- Shared package `l2_arb_pkg`:
  - `arb_state_t` enum: `IDLE`, `SERVE_I`, `SERVE_D`.
  - `grant_t` enum: `GRANT_I`, `GRANT_D`.
  - Line-width constant: 256.
- Single module with no sub-modules. It contains:
  - state register;
  - command latches;
  - `last_grant` flop;
  - combinational next-state and output-select logic.
- Estimated size: about 150 lines.

## Test plan
- **Reset:** hold `rst` for 2 cycles with both requests high → every output is 0 during reset. First grant after reset is I.
- **Single I read:** `i_mem_read` with address 0x0000_1234 → `l2_read`=1 and `l2_address`=0x0000_1220 one cycle later. L2 `resp` after 5 cycles → `i_mem_resp` pulses for one cycle with data 0xA5…A5.
- **Single D write:** `d_mem_write`, address 0x8000_0040, wdata 0x1111…1 → `l2_write`=1 with latched data. Changing `d_mem_wdata` mid-transaction does not alter `l2_wdata`.
- **Round-robin:** I and D requests held continuously → grants alternate I, D, I, D. Each is separated by exactly one IDLE cycle.
- **Resp steering:** during `SERVE_D`, pulse `l2_resp` → only `d_mem_resp` fires. `i_mem_resp` stays 0 throughout.
- **Mid-transaction reset:** assert `rst` during `SERVE_I` → `l2_read` is 0 the next cycle and no `i_mem_resp` is produced. A later `l2_resp` pulse seen in IDLE is ignored.
